// File: rtl/fifo_wr_arb.sv
// Two-requester round-robin arbiter feeding the write side of an async FIFO.
// Frames longer than MAX_LEN are cut: the last written beat is marked final and the rest are drained unwritten.
//
//   state | meaning
//   IDLE  | no owner; arbitrate when the FIFO has room
//   PASS  | granted requester streams beats into the FIFO
//   DROP  | frame truncated; accept and discard beats until last
module fifo_wr_arb #(
  parameter int DW      = 8,
  parameter int MAX_LEN = 1518,
  parameter int CNTW    = 11
) (
  input  logic          wclk,
  input  logic          wrst_n,
  input  logic          s0_valid,
  input  logic [DW-1:0] s0_data,
  input  logic          s0_last,
  output logic          s0_ready,
  input  logic          s1_valid,
  input  logic [DW-1:0] s1_data,
  input  logic          s1_last,
  output logic          s1_ready,
  input  logic          wfull,
  output logic          winc,
  output logic [DW:0]   wdata,
  output logic          trunc,
  output logic          trunc_port,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } state_e;

  localparam logic [CNTW-1:0] LIMIT = CNTW'(MAX_LEN - 1);

  state_e          state_q;
  logic            g_q;
  logic            lastg_q;
  logic [CNTW-1:0] cnt_q;
  logic [CNTW-1:0] cnt_d;
  logic            trunc_q;
  logic            trunc_port_q;

  logic            sel_valid;
  logic            sel_last;
  logic [DW-1:0]   sel_data;
  logic            in_pass;
  logic            in_drop;
  logic            at_limit;
  logic            sel_ready;
  logic            accept;
  logic            winner;

  assign sel_valid = g_q ? s1_valid : s0_valid;
  assign sel_last  = g_q ? s1_last  : s0_last;
  assign sel_data  = g_q ? s1_data  : s0_data;

  assign in_pass  = (state_q == PASS);
  assign in_drop  = (state_q == DROP);
  assign at_limit = (cnt_q == LIMIT);
  assign cnt_d    = cnt_q + CNTW'(1);

  // DROP drains regardless of wfull since nothing is written.
  assign sel_ready = (in_pass & ~wfull) | in_drop;
  assign accept    = sel_valid & sel_ready;

  assign s0_ready   = sel_ready & ~g_q;
  assign s1_ready   = sel_ready & g_q;
  assign winc       = in_pass & sel_valid & ~wfull;
  assign wdata      = {sel_last | (in_pass & at_limit), sel_data};
  assign busy       = (state_q != IDLE);
  assign trunc      = trunc_q;
  assign trunc_port = trunc_port_q;

  // Sole requester wins outright; on a tie the one not served last wins.
  assign winner = (s0_valid & s1_valid) ? ~lastg_q : s1_valid;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q      <= IDLE;
      g_q          <= 1'b0;
      lastg_q      <= 1'b1;
      cnt_q        <= '0;
      trunc_q      <= 1'b0;
      trunc_port_q <= 1'b0;
    end else begin
      trunc_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!wfull && (s0_valid || s1_valid)) begin
            g_q     <= winner;
            lastg_q <= winner;
            cnt_q   <= '0;
            state_q <= PASS;
          end
        end
        PASS: begin
          if (accept) begin
            if (sel_last) begin
              state_q <= IDLE;
            end else if (at_limit) begin
              state_q      <= DROP;
              trunc_q      <= 1'b1;
              trunc_port_q <= g_q;
            end else begin
              cnt_q <= cnt_d;
            end
          end
        end
        DROP: begin
          if (accept && sel_last) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: one default instance and one with MAX_LEN=4, each checked
// every cycle against a frame-level model, plus hand-computed directed results.
module tb_fifo_wr_arb;
  localparam int DW = 8;

  logic wclk = 1'b0;
  logic wrst_n = 1'b1;
  always #5 wclk = ~wclk;

  // Source index = 2*instance + port.
  wire  [3:0]    s_valid;
  wire  [3:0]    s_last;
  wire  [3:0]    rdy;
  wire  [DW-1:0] s_data [4];
  wire  [DW:0]   s_word [4];
  logic [1:0]    wfull;
  wire  [1:0]    winc;
  wire  [1:0]    trunc;
  wire  [1:0]    tport;
  wire  [1:0]    busy;
  wire  [DW:0]   wdata0;
  wire  [DW:0]   wdata1;

  logic [DW:0] src_mem [4][64];
  int          src_rd [4];
  int          src_wr [4];
  logic [3:0]  fire;

  logic [DW:0] log_mem [2][64];
  int          log_n [2];
  int          trunc_cnt [2];
  int          last_tport [2];

  int errors = 0;
  int checks = 0;

  for (genvar i = 0; i < 4; i++) begin : g_src
    assign s_valid[i] = (src_rd[i] != src_wr[i]);
    assign s_word[i]  = src_mem[i][src_rd[i][5:0]];
    assign s_data[i]  = s_word[i][DW-1:0];
    assign s_last[i]  = s_word[i][DW];
  end

  fifo_wr_arb #(.DW(DW)) dut0 (
    .wclk(wclk), .wrst_n(wrst_n),
    .s0_valid(s_valid[0]), .s0_data(s_data[0]), .s0_last(s_last[0]), .s0_ready(rdy[0]),
    .s1_valid(s_valid[1]), .s1_data(s_data[1]), .s1_last(s_last[1]), .s1_ready(rdy[1]),
    .wfull(wfull[0]), .winc(winc[0]), .wdata(wdata0),
    .trunc(trunc[0]), .trunc_port(tport[0]), .busy(busy[0])
  );

  fifo_wr_arb #(.DW(DW), .MAX_LEN(4), .CNTW(3)) dut1 (
    .wclk(wclk), .wrst_n(wrst_n),
    .s0_valid(s_valid[2]), .s0_data(s_data[2]), .s0_last(s_last[2]), .s0_ready(rdy[2]),
    .s1_valid(s_valid[3]), .s1_data(s_data[3]), .s1_last(s_last[3]), .s1_ready(rdy[3]),
    .wfull(wfull[1]), .winc(winc[1]), .wdata(wdata1),
    .trunc(trunc[1]), .trunc_port(tport[1]), .busy(busy[1])
  );

  task automatic chk(input string nm, input int k, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s (inst %0d): got %0d expected %0d at %0t", nm, k, got, exp, $time);
    end
  endtask

  task automatic push(input int idx, input int port, input int frame, input int n);
    for (int b = 0; b < n; b++) begin
      src_mem[idx][src_wr[idx]] = {1'(b == n - 1), 1'(port), 3'(frame), 4'(b)};
      src_wr[idx]++;
    end
  endtask

  task automatic wait_done(input int k, input int budget);
    int  n;
    bit  done;
    n = 0;
    done = 0;
    while (!done && n < budget) begin
      @(posedge wclk);
      #2;
      n++;
      if (busy[k] == 1'b0 && src_rd[2*k] == src_wr[2*k] && src_rd[2*k+1] == src_wr[2*k+1])
        done = 1;
    end
    chk("wait_done_in_time", k, int'(done), 1);
  endtask

  task automatic wait_log(input int k, input int target, input int budget);
    int n;
    n = 0;
    while (log_n[k] != target && n < budget) begin
      @(posedge wclk);
      #1;
      n++;
    end
    chk("wait_log_in_time", k, log_n[k], target);
  endtask

  task automatic do_reset();
    @(posedge wclk);
    #1 wrst_n = 1'b0;
    repeat (2) @(posedge wclk);
    #1 wrst_n = 1'b1;
  endtask

  // Source pointers advance on beats that transferred at the previous edge.
  always @(posedge wclk) begin
    #1;
    for (int i = 0; i < 4; i++)
      if (fire[i]) src_rd[i]++;
  end

  // Frame-level model: who owns the FIFO, how many beats of this frame were written, draining or not.
  bit m_busy [2];
  bit m_drop [2];
  bit m_own  [2];
  bit m_prio [2];
  bit m_trunc [2];
  bit m_tport [2];
  int m_n [2];

  int          L, i0;
  bit          e_rown, e_winc;
  logic [DW:0] e_wd;
  logic [DW:0] a_wd;

  always @(negedge wclk) begin
    for (int k = 0; k < 2; k++) begin
      L = (k == 0) ? 1518 : 4;
      if (!wrst_n) begin
        m_busy[k] = 0; m_drop[k] = 0; m_own[k] = 0; m_prio[k] = 0;
        m_trunc[k] = 0; m_tport[k] = 0; m_n[k] = 0;
      end
      i0 = 2 * k + int'(m_own[k]);
      e_rown = 0;
      e_winc = 0;
      if (m_busy[k]) begin
        if (m_drop[k]) e_rown = 1;
        else begin
          e_rown = !wfull[k];
          e_winc = s_valid[i0] && !wfull[k];
        end
      end
      e_wd = {s_last[i0] | (m_busy[k] && !m_drop[k] && m_n[k] == L - 1), s_data[i0]};
      a_wd = (k == 0) ? wdata0 : wdata1;

      chk("busy", k, int'(busy[k]), int'(m_busy[k]));
      chk("ready0", k, int'(rdy[2*k]), int'(e_rown && m_own[k] == 0));
      chk("ready1", k, int'(rdy[2*k+1]), int'(e_rown && m_own[k] == 1));
      chk("winc", k, int'(winc[k]), int'(e_winc));
      if (e_winc) chk("wdata", k, int'(a_wd), int'(e_wd));
      chk("trunc", k, int'(trunc[k]), int'(m_trunc[k]));
      if (m_trunc[k]) chk("trunc_port", k, int'(tport[k]), int'(m_tport[k]));

      fire[2*k]   = s_valid[2*k] & rdy[2*k];
      fire[2*k+1] = s_valid[2*k+1] & rdy[2*k+1];
      if (winc[k] && log_n[k] < 64) begin
        log_mem[k][log_n[k]] = a_wd;
        log_n[k]++;
      end
      if (trunc[k]) begin
        trunc_cnt[k]++;
        last_tport[k] = int'(tport[k]);
      end

      if (wrst_n) begin
        m_trunc[k] = 0;
        if (!m_busy[k]) begin
          if (!wfull[k] && (s_valid[2*k] || s_valid[2*k+1])) begin
            m_own[k]  = (s_valid[2*k] && s_valid[2*k+1]) ? m_prio[k] : s_valid[2*k+1];
            m_prio[k] = !m_own[k];
            m_busy[k] = 1;
            m_drop[k] = 0;
            m_n[k]    = 0;
          end
        end else if (!m_drop[k]) begin
          if (s_valid[i0] && !wfull[k]) begin
            if (s_last[i0]) m_busy[k] = 0;
            else if (m_n[k] == L - 1) begin
              m_drop[k]  = 1;
              m_trunc[k] = 1;
              m_tport[k] = m_own[k];
            end else m_n[k]++;
          end
        end else if (s_valid[i0] && s_last[i0]) begin
          m_busy[k] = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    int base, base2, tb0;
    logic [DW:0] w;
    wfull = 2'b00;
    fire  = 4'b0000;
    for (int i = 0; i < 4; i++) begin src_rd[i] = 0; src_wr[i] = 0; end
    for (int k = 0; k < 2; k++) begin log_n[k] = 0; trunc_cnt[k] = 0; last_tport[k] = 0; end

    // Reset values
    #1 wrst_n = 1'b0;
    #1;
    chk("rst_busy", 0, int'(busy), 0);
    chk("rst_winc", 0, int'(winc), 0);
    chk("rst_ready", 0, int'(rdy), 0);
    chk("rst_trunc", 0, int'(trunc), 0);
    chk("rst_tport", 0, int'(tport), 0);
    repeat (3) @(posedge wclk);
    #1 wrst_n = 1'b1;

    // Single 4-beat frame on s0
    base = log_n[0];
    push(0, 0, 1, 4);
    @(negedge wclk);
    chk("t1_busy_before_grant", 0, int'(busy[0]), 0);
    @(negedge wclk);
    chk("t1_busy_after_grant", 0, int'(busy[0]), 1);
    wait_done(0, 50);
    chk("t1_writes", 0, log_n[0] - base, 4);
    for (int b = 0; b < 4; b++)
      chk("t1_word", 0, int'(log_mem[0][base+b]), (b == 3 ? 9'h100 : 9'h000) + 9'h010 + b);

    // Tie from reset: s0, s1, s0, s1
    do_reset();
    base = log_n[0];
    push(0, 0, 0, 3);
    push(0, 0, 1, 3);
    push(1, 1, 0, 3);
    push(1, 1, 1, 3);
    wait_done(0, 100);
    chk("t2_writes", 0, log_n[0] - base, 12);
    for (int f = 0; f < 4; f++)
      for (int b = 0; b < 3; b++) begin
        w = {1'(b == 2), 1'(f % 2), 3'(f / 2), 4'(b)};
        chk("t2_order", 0, int'(log_mem[0][base + 3*f + b]), int'(w));
      end

    // Backpressure at beat 2 of a 5-beat frame
    base = log_n[0];
    push(0, 0, 2, 5);
    wait_log(0, base + 1, 50);
    wfull[0] = 1'b1;
    @(negedge wclk);
    chk("t3_stall_winc", 0, int'(winc[0]), 0);
    chk("t3_stall_ready", 0, int'(rdy[0]), 0);
    @(posedge wclk);
    @(negedge wclk);
    chk("t3_stall2_winc", 0, int'(winc[0]), 0);
    @(posedge wclk);
    #1 wfull[0] = 1'b0;
    wait_done(0, 50);
    chk("t3_writes", 0, log_n[0] - base, 5);
    for (int b = 0; b < 5; b++)
      chk("t3_word", 0, int'(log_mem[0][base+b]), (b == 4 ? 9'h100 : 9'h000) + 9'h020 + b);

    // Truncation: 7-beat frame on s1, MAX_LEN=4
    base = log_n[1];
    tb0  = trunc_cnt[1];
    push(3, 1, 3, 7);
    wait_done(1, 60);
    chk("t4_writes", 1, log_n[1] - base, 4);
    for (int b = 0; b < 4; b++)
      chk("t4_word", 1, int'(log_mem[1][base+b]), (b == 3 ? 9'h100 : 9'h000) + 9'h0B0 + b);
    chk("t4_trunc_pulses", 1, trunc_cnt[1] - tb0, 1);
    chk("t4_trunc_port", 1, last_tport[1], 1);

    // Exact limit: 4-beat frame on s0, MAX_LEN=4
    base = log_n[1];
    tb0  = trunc_cnt[1];
    push(2, 0, 4, 4);
    wait_done(1, 40);
    chk("t5_writes", 1, log_n[1] - base, 4);
    chk("t5_no_trunc", 1, trunc_cnt[1] - tb0, 0);
    chk("t5_last_word", 1, int'(log_mem[1][base+3]), 9'h143);

    // Reset mid-frame at beat 3, then tie resolves to s0
    base = log_n[0];
    push(0, 0, 5, 6);
    wait_log(0, base + 2, 50);
    wrst_n = 1'b0;
    #1;
    chk("t6_winc_in_reset", 0, int'(winc[0]), 0);
    chk("t6_busy_in_reset", 0, int'(busy[0]), 0);
    chk("t6_ready_in_reset", 0, int'(rdy[0]), 0);
    repeat (2) @(posedge wclk);
    #1;
    for (int i = 0; i < 4; i++) src_wr[i] = src_rd[i];
    push(0, 0, 6, 2);
    push(1, 1, 6, 2);
    @(posedge wclk);
    #1 wrst_n = 1'b1;
    chk("t6_abandoned", 0, log_n[0] - base, 2);
    base2 = log_n[0];
    wait_done(0, 50);
    chk("t6_writes", 0, log_n[0] - base2, 4);
    chk("t6_w0", 0, int'(log_mem[0][base2]),   9'h060);
    chk("t6_w1", 0, int'(log_mem[0][base2+1]), 9'h161);
    chk("t6_w2", 0, int'(log_mem[0][base2+2]), 9'h0E0);
    chk("t6_w3", 0, int'(log_mem[0][base2+3]), 9'h1E1);

    repeat (2) @(posedge wclk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
